// File: rtl/seq_mul_ctrl.sv
// Shift-add unsigned multiplier controller: accepts A,B, iterates one multiplier bit per clock, holds A*B.
// Latency: WIDTH cycles accept->out_valid; with SEQMUL_EARLY_TERM_EN, stops after the multiplier MSB plus one align cycle.
// Backpressure: product held in DONE until out_ready; in_ready is low from accept until the handoff edge.
module seq_mul_ctrl #(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 abort,
    output logic                 busy,
    output logic [CNT_W-1:0]     step,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_ALIGN
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  m_q;
    logic [WIDTH-1:0]  h_q;
    logic [WIDTH-1:0]  l_q;
    logic [CNT_W-1:0]  step_q;

    // The carry bit C only exists between the add and the shift, so it lives in sum[WIDTH].
    logic [WIDTH:0]    sum;
    logic [CNT_W-1:0]  step_nxt;
    logic              last_iter;

    always_comb begin
        sum       = {1'b0, h_q} + {1'b0, (l_q[0] ? m_q : {WIDTH{1'b0}})};
        step_nxt  = step_q + 1'b1;
        last_iter = (step_nxt == CNT_W'(WIDTH));
    end

`ifdef SEQMUL_EARLY_TERM_EN
    // Bits of L above the current LSB that are still unconsumed multiplier bits.
    logic [WIDTH-2:0]   rem_mask;
    logic               rem_zero;
    logic [CNT_W-1:0]   shamt;
    logic [2*WIDTH-1:0] aligned;

    always_comb begin
        rem_mask = {(WIDTH-1){1'b1}} >> step_q;
        rem_zero = ((l_q[WIDTH-1:1] & rem_mask) == '0);
        shamt    = CNT_W'(WIDTH) - step_q;
        aligned  = {h_q, l_q} >> shamt;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            step_q    <= '0;
            m_q       <= '0;
            h_q       <= '0;
            l_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && !abort) begin
                        m_q      <= multiplicand;
                        l_q      <= multiplier;
                        h_q      <= '0;
                        step_q   <= '0;
                        state_q  <= S_RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state_q  <= S_IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        h_q    <= sum[WIDTH:1];
                        l_q    <= {sum[0], l_q[WIDTH-1:1]};
                        step_q <= step_nxt;
                        if (last_iter) begin
                            state_q   <= S_DONE;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                        end
`ifdef SEQMUL_EARLY_TERM_EN
                        else if (rem_zero) begin
                            state_q <= S_ALIGN;
                        end
`endif
                    end
                end
`ifdef SEQMUL_EARLY_TERM_EN
                S_ALIGN: begin
                    if (abort) begin
                        state_q  <= S_IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        {h_q, l_q} <= aligned;
                        step_q     <= CNT_W'(WIDTH);
                        state_q    <= S_DONE;
                        busy       <= 1'b0;
                        out_valid  <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    // abort wins over out_ready: either way we return to IDLE.
                    if (abort || out_ready) begin
                        state_q   <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign step    = step_q;
    assign product = {h_q, l_q};

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Directed test of seq_mul_ctrl at WIDTH=16: reset, products, carry, backpressure, abort, async reset.
module tb_seq_mul_ctrl;

    localparam int W     = 16;
    localparam int CNT_W = $clog2(W) + 1;
`ifdef SEQMUL_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     multiplicand = '0;
    logic [W-1:0]     multiplier = '0;
    logic             abort = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] step;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [2*W-1:0]   product;

    int checks = 0;
    int errors = 0;

    seq_mul_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .abort        (abort),
        .busy         (busy),
        .step         (step),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int lat_for(input int early_lat);
        return EARLY ? early_lat : W;
    endfunction

    // Accept one operand pair and count cycles until out_valid; -1 on timeout.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        multiplicand = a;
        multiplier   = b;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (step !== '0) begin errors++; $display("FAIL reset_step: got %0d expected 0", step); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (product !== 32'h0) begin errors++; $display("FAIL reset_product: got %h expected 00000000", product); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        int lat;
        out_ready    = 1'b1;
        multiplicand = 16'h0003;
        multiplier   = 16'h0005;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1 || step !== '0) begin
            errors++; $display("FAIL basic_accept: in_ready=%b busy=%b step=%0d expected 0 1 0", in_ready, busy, step);
        end
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (out_valid) begin lat = n; break; end
        end
        checks++; if (lat != lat_for(4)) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, lat_for(4)); end
        checks++; if (product !== 32'h0000000F) begin errors++; $display("FAIL basic_product: got %h expected 0000000f", product); end
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_handoff: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_carry;
        int lat;
        out_ready = 1'b1;
        run_op(16'hFFFF, 16'hFFFF, lat);
        checks++; if (lat != 16) begin errors++; $display("FAIL carry_latency: got %0d expected 16", lat); end
        checks++; if (product !== 32'hFFFE0001) begin errors++; $display("FAIL carry_product: got %h expected fffe0001", product); end
        checks++; if (product[31:16] !== 16'hFFFE) begin errors++; $display("FAIL carry_high: got %h expected fffe", product[31:16]); end
        tick();
    endtask

    task automatic test_backpressure;
        int lat;
        out_ready = 1'b0;
        run_op(16'h1234, 16'h0010, lat);
        checks++; if (lat != lat_for(6)) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", lat, lat_for(6)); end
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            tick();
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== 32'h00012340) begin
                errors++; $display("FAIL bp_hold: out_valid=%b in_ready=%b product=%h expected 1 0 00012340", out_valid, in_ready, product);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_handoff: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        tick();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_single: out_valid=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_abort;
        int lat;
        int seen;
        out_ready    = 1'b1;
        multiplicand = 16'h00FF;
        multiplier   = 16'h0F0F;
        in_valid     = 1'b1;
        abort        = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_idle: in_ready=%b busy=%b expected 1 0", in_ready, busy);
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int n = 0; n < 40 && step != 7; n++) tick();
        checks++; if (step !== 5'd7) begin errors++; $display("FAIL abort_reach_step: got %0d expected 7", step); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL abort_run: busy=%b in_ready=%b out_valid=%b expected 0 1 0", busy, in_ready, out_valid);
        end
        seen = 0;
        for (int n = 0; n < 25; n++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_valid: got %0d valid cycles expected 0", seen); end
        run_op(16'h0002, 16'h0003, lat);
        checks++; if (lat != lat_for(3)) begin errors++; $display("FAIL abort_next_latency: got %0d expected %0d", lat, lat_for(3)); end
        checks++; if (product !== 32'h00000006) begin errors++; $display("FAIL abort_next_product: got %h expected 00000006", product); end
        tick();
    endtask

    task automatic test_reset_mid_run;
        int lat;
        out_ready    = 1'b1;
        multiplicand = 16'h1111;
        multiplier   = 16'hFFFF;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int n = 0; n < 40 && step != 9; n++) tick();
        checks++; if (step !== 5'd9) begin errors++; $display("FAIL rst_reach_step: got %0d expected 9", step); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || step !== '0 || out_valid !== 1'b0 || product !== 32'h0) begin
            errors++; $display("FAIL rst_async: in_ready=%b busy=%b step=%0d out_valid=%b product=%h expected 1 0 0 0 00000000",
                               in_ready, busy, step, out_valid, product);
        end
        tick();
        rst_n = 1'b1;
        tick();
        run_op(16'h8000, 16'h0002, lat);
        checks++; if (lat != lat_for(3)) begin errors++; $display("FAIL rst_next_latency: got %0d expected %0d", lat, lat_for(3)); end
        checks++; if (product !== 32'h00010000) begin errors++; $display("FAIL rst_next_product: got %h expected 00010000", product); end
        tick();
    endtask

`ifdef SEQMUL_EARLY_TERM_EN
    task automatic test_early_term;
        int lat;
        out_ready = 1'b1;
        run_op(16'hABCD, 16'h0001, lat);
        checks++; if (lat != 2 || product !== 32'h0000ABCD) begin
            errors++; $display("FAIL et_one: lat=%0d product=%h expected 2 0000abcd", lat, product);
        end
        tick();
        run_op(16'h1234, 16'h0000, lat);
        checks++; if (lat != 2 || product !== 32'h0) begin
            errors++; $display("FAIL et_zero: lat=%0d product=%h expected 2 00000000", lat, product);
        end
        tick();
        run_op(16'h0001, 16'h8000, lat);
        checks++; if (lat != 16 || product !== 32'h00008000) begin
            errors++; $display("FAIL et_msb: lat=%0d product=%h expected 16 00008000", lat, product);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_abort();
        test_reset_mid_run();
`ifdef SEQMUL_EARLY_TERM_EN
        test_early_term();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
